// File: rtl/hex_marquee_scroller.sv
// Latches a message of 3-bit char codes and scrolls it across NUM_DIGITS seven-segment digits; optional wrap dwell under MARQUEE_WRAP_HOLD_EN.
// HEX follows buffer/offset by one cycle; offset/running are registered; no backpressure, load/step are level-sampled.
module hex_marquee_scroller #(
  parameter int NUM_DIGITS = 8,
  parameter int MSG_LEN    = 8,
  parameter int TICK_DIV   = 25000000,
  parameter int HOLD_TICKS = 4
) (
  input  logic                         CLOCK_50,
  input  logic                         RESET,
  input  logic [MSG_LEN*3-1:0]         msg_codes,
  input  logic                         load,
  input  logic                         enable,
  input  logic                         dir,
  input  logic                         step,
  output logic [NUM_DIGITS*7-1:0]      HEX,
  output logic [$clog2(MSG_LEN)-1:0]   offset,
  output logic                         running
);

  localparam int OW = $clog2(MSG_LEN);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [OW-1:0] OFS_LAST = OW'(MSG_LEN - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  if (MSG_LEN < 2 || TICK_DIV < 2 || HOLD_TICKS < 1) begin : g_param_check
    $error("hex_marquee_scroller: MSG_LEN and TICK_DIV must be >= 2, HOLD_TICKS >= 1");
  end

`ifdef MARQUEE_WRAP_HOLD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  logic [HW-1:0] hold_cnt, hold_nxt;
`else
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
`endif

  state_t                  state, state_nxt;
  logic [PW-1:0]           presc, presc_nxt;
  logic [OW-1:0]           offset_nxt, offset_step;
  logic                    tick;
  logic [2:0]              chars [MSG_LEN];
  logic [NUM_DIGITS*7-1:0] hex_nxt;

  function automatic logic [6:0] seg_decode(input logic [2:0] code);
    case (code)
      3'b000:  seg_decode = 7'b1001000;
      3'b001:  seg_decode = 7'b0110000;
      3'b010:  seg_decode = 7'b1110001;
      3'b011:  seg_decode = 7'b0000001;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Modular wrap so NUM_DIGITS > MSG_LEN simply repeats the message.
  function automatic logic [OW-1:0] char_index(input logic [OW-1:0] ofs, input int j);
    return OW'((int'(ofs) + j) % MSG_LEN);
  endfunction

  always_comb begin
    state_nxt  = state;
    presc_nxt  = '0;
    offset_nxt = offset;
    tick       = 1'b0;
`ifdef MARQUEE_WRAP_HOLD_EN
    hold_nxt   = hold_cnt;
`endif
    offset_step = dir ? ((offset == '0) ? OFS_LAST : offset - OW'(1))
                      : ((offset == OFS_LAST) ? '0 : offset + OW'(1));

    if (state != IDLE && enable) begin
      tick      = (presc == PRE_LAST);
      presc_nxt = tick ? '0 : presc + PW'(1);
    end

    case (state)
      IDLE: begin
        if (step) offset_nxt = offset_step;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (tick) begin
          offset_nxt = offset_step;
`ifdef MARQUEE_WRAP_HOLD_EN
          if (offset_step == '0) begin
            state_nxt = HOLD;
            hold_nxt  = '0;
          end
`endif
        end
      end
`ifdef MARQUEE_WRAP_HOLD_EN
      HOLD: begin
        if (!enable) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else if (tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_nxt = RUN;
            hold_nxt  = '0;
          end else begin
            hold_nxt = hold_cnt + HW'(1);
          end
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase

    // load wins over a coincident tick or step; the tick is simply dropped.
    if (load) begin
      offset_nxt = '0;
      presc_nxt  = '0;
`ifdef MARQUEE_WRAP_HOLD_EN
      hold_nxt   = '0;
      if (state_nxt == HOLD) state_nxt = RUN;
`endif
    end
  end

  always_comb begin
    hex_nxt = '1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      hex_nxt[(NUM_DIGITS-1-j)*7 +: 7] = seg_decode(chars[char_index(offset, j)]);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      presc   <= '0;
      offset  <= '0;
      running <= 1'b0;
      HEX     <= '1;
`ifdef MARQUEE_WRAP_HOLD_EN
      hold_cnt <= '0;
`endif
      for (int i = 0; i < MSG_LEN; i++) chars[i] <= 3'b111;
    end else begin
      presc   <= presc_nxt;
      offset  <= offset_nxt;
      running <= (state_nxt != IDLE);
      HEX     <= hex_nxt;
`ifdef MARQUEE_WRAP_HOLD_EN
      hold_cnt <= hold_nxt;
`endif
      if (load) begin
        for (int i = 0; i < MSG_LEN; i++) chars[i] <= msg_codes[(MSG_LEN-1-i)*3 +: 3];
      end
    end
  end

endmodule

// File: tb/tb_hex_marquee_scroller.sv
// Directed bench for hex_marquee_scroller: an event-level reference model checked every cycle plus hand-computed literals.
module tb_hex_marquee_scroller;

  localparam int ND = 8;
  localparam int ML = 8;
  localparam int TD = 4;
  localparam int HT = 2;
  localparam logic [23:0] HELLO = {3'b000, 3'b001, 3'b010, 3'b010, 3'b011, 3'b111, 3'b111, 3'b111};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [23:0]   msg_codes = '0;
  logic          load = 1'b0, enable = 1'b0, dir = 1'b0, step = 1'b0;
  logic [55:0]   hex;
  logic [2:0]    offset;
  logic          running;

  int checks = 0;
  int errors = 0;

  hex_marquee_scroller #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .CLOCK_50(clk), .RESET(rst), .msg_codes(msg_codes), .load(load), .enable(enable),
    .dir(dir), .step(step), .HEX(hex), .offset(offset), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: message as an int array, position as an int, run phase counted in cycles.
  int   m_buf [ML];
  int   m_off = 0;
  int   m_cnt = 0;
  int   m_hold_left = 0;
  bit   m_active = 0;
  bit   m_valid = 0;
  logic [55:0] exp_hex;

  function automatic logic [6:0] seg_of(input int c);
    if (c >= 4) return 7'b1111111;
    if (c == 0) return 7'b1001000;
    if (c == 1) return 7'b0110000;
    if (c == 2) return 7'b1110001;
    return 7'b0000001;
  endfunction

  function automatic logic [55:0] render();
    logic [55:0] r;
    r = '1;
    for (int j = 0; j < ND; j++) r[(ND-1-j)*7 +: 7] = seg_of(m_buf[(m_off + j) % ML]);
    return r;
  endfunction

  always @(posedge clk) begin
    bit tk;
    if (rst) begin
      for (int i = 0; i < ML; i++) m_buf[i] = 7;
      m_off = 0; m_cnt = 0; m_hold_left = 0; m_active = 0;
      exp_hex = '1;
      m_valid = 1;
    end else begin
      exp_hex = render();
      tk = 0;
      if (m_active && enable) begin
        m_cnt++;
        if (m_cnt == TD) begin tk = 1; m_cnt = 0; end
      end else begin
        m_cnt = 0;
      end
      if (load) begin
        for (int i = 0; i < ML; i++) m_buf[i] = int'(msg_codes[(ML-1-i)*3 +: 3]);
        m_off = 0; m_cnt = 0; m_hold_left = 0;
      end else if (tk) begin
        if (m_hold_left > 0) begin
          m_hold_left--;
        end else begin
          m_off = (m_off + (dir ? ML - 1 : 1)) % ML;
`ifdef MARQUEE_WRAP_HOLD_EN
          if (m_off == 0) m_hold_left = HT;
`endif
        end
      end else if (!m_active && step) begin
        m_off = (m_off + (dir ? ML - 1 : 1)) % ML;
      end
      if (!enable) begin m_active = 0; m_hold_left = 0; end
      else m_active = 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("hex_model", 64'(hex), 64'(exp_hex));
      chk("offset_model", 64'(offset), 64'(m_off));
      chk("running_model", 64'(running), 64'(m_active));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("reset_hex", 64'(hex), 64'h00FF_FFFF_FFFF_FFFF);
    chk("reset_offset", 64'(offset), 64'd0);
    chk("reset_running", 64'(running), 64'd0);

    msg_codes = HELLO; load = 1'b1; cyc(1); load = 1'b0;
    chk("load_offset", 64'(offset), 64'd0);
    cyc(1);
    chk("load_left_H", 64'(hex[55:49]), 64'(7'b1001000));
    chk("load_digit4_O", 64'(hex[27:21]), 64'(7'b0000001));

    enable = 1'b1; dir = 1'b0; cyc(1);
    chk("run_entry", 64'(running), 64'd1);
    cyc(4);
    chk("first_tick", 64'(offset), 64'd1);
    cyc(1);
    chk("left_E", 64'(hex[55:49]), 64'(7'b0110000));
    cyc(27);
    chk("wrap_32", 64'(offset), 64'd0);
    cyc(4);
`ifdef MARQUEE_WRAP_HOLD_EN
    chk("after_wrap_36", 64'(offset), 64'd0);
    cyc(7);
    chk("after_wrap_43", 64'(offset), 64'd0);
    cyc(1);
    chk("after_wrap_44", 64'(offset), 64'd1);
`else
    chk("after_wrap_36", 64'(offset), 64'd1);
    cyc(7);
    chk("after_wrap_43", 64'(offset), 64'd2);
    cyc(1);
    chk("after_wrap_44", 64'(offset), 64'd3);
`endif

    enable = 1'b0; cyc(1);
    chk("stop_running", 64'(running), 64'd0);
    load = 1'b1; cyc(1); load = 1'b0;
    dir = 1'b1; step = 1'b1; cyc(1); step = 1'b0;
    chk("step_right_wrap", 64'(offset), 64'd7);
    cyc(1);
    chk("step_left_blank", 64'(hex[55:49]), 64'(7'b1111111));
    chk("step_digit1_H", 64'(hex[48:42]), 64'(7'b1001000));
    enable = 1'b1; cyc(1);
    step = 1'b1; cyc(1); step = 1'b0;
    chk("step_ignored_run", 64'(offset), 64'd7);
    enable = 1'b0; cyc(1);
    chk("step_ignored_stop", 64'(offset), 64'd7);

    dir = 1'b0; enable = 1'b1; cyc(1);
    cyc(3);
    load = 1'b1; cyc(1); load = 1'b0;
    chk("collide_offset", 64'(offset), 64'd0);
    chk("collide_running", 64'(running), 64'd1);
    cyc(3);
    chk("collide_hold", 64'(offset), 64'd0);
    cyc(1);
    chk("collide_next_move", 64'(offset), 64'd1);
    cyc(2);
    dir = 1'b1; cyc(2);
    chk("dir_toggle_mid", 64'(offset), 64'd0);

    cyc(1);
    rst = 1'b1; cyc(1); rst = 1'b0; enable = 1'b0;
    chk("midrst_hex", 64'(hex), 64'h00FF_FFFF_FFFF_FFFF);
    chk("midrst_offset", 64'(offset), 64'd0);
    chk("midrst_running", 64'(running), 64'd0);
    cyc(2);
    chk("midrst_msg_lost", 64'(hex), 64'h00FF_FFFF_FFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_marquee_scroller.md
# hex_marquee_scroller

Parametrised, self-clocked successor to the switch-selected 8-digit HELLO rotator. It latches a message of 3-bit character codes into an internal buffer, then scrolls it across NUM_DIGITS seven-segment displays at a prescaled rate. It supports direction control, run/stop, and manual single-step. The block sits between the board switch/key inputs and the HEX display pins on the DE2 top level.

## Interface
- NUM_DIGITS, 8: number of seven-segment digits driven.
- MSG_LEN, 8: message length in characters, ≥2.
- TICK_DIV, 25000000: clock cycles per scroll step (0.5 s at 50 MHz), ≥2.
- HOLD_TICKS, 4: dwell length in scroll ticks at wrap; used only with the macro.
- CLOCK_50  in  1  system clock, all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- msg_codes  in  MSG_LEN*3  message characters; char 0 (leftmost) is in the top 3 bits.
- load  in  1  1-cycle pulse that captures msg_codes into the buffer.
- enable  in  1  1 = auto-scroll, 0 = stopped.
- dir  in  1  0 = text moves left (offset +1), 1 = text moves right (offset −1).
- step  in  1  1-cycle pulse that advances one position; honoured only when stopped.
- HEX  out  NUM_DIGITS*7  active-low segments; the top 7 bits are the leftmost digit; within each digit the order is a..g, MSB first.
- offset  out  clog2(MSG_LEN)  current scroll position.
- running  out  1  high in RUN or HOLD.

## Operation
- **Code decode** (active-low a..g):
  - 000 H = 1001000
  - 001 E = 0110000
  - 010 L = 1110001
  - 011 O = 0000001
  - 1xx blank = 1111111
- **Digit mapping:** leftmost digit j=0 shows buffer char (offset + j) mod MSG_LEN. Digit j shows char (offset + j) mod MSG_LEN. Wrap is modular even when NUM_DIGITS > MSG_LEN, in which case chars repeat.
- **State machine:**
  - IDLE: enable=0. Offset frozen. Prescaler held at 0.
  - RUN: enable=1. Prescaler counts 0..TICK_DIV−1. On the terminal count it returns to 0 and issues a tick. Each tick moves offset by ±1 mod MSG_LEN, per dir sampled on the tick cycle.
  - HOLD: macro only; see Configuration.
  - IDLE→RUN when enable=1. RUN/HOLD→IDLE when enable=0. Prescaler clears on entry to IDLE.
- **Offset wrap:** left from MSG_LEN−1 goes to 0. Right from 0 goes to MSG_LEN−1.
- **load:** buffer ← msg_codes, offset ← 0, prescaler ← 0. If in HOLD, go to RUN. State is otherwise unchanged.
- **Priority within one cycle:** RESET > load > tick/step. A tick coinciding with load is discarded.
- **step:** in IDLE, moves offset by ±1 per dir. Ignored in RUN/HOLD.
- **Reset values:**
  - buffer: all 3'b111 (blank)
  - offset 0
  - prescaler 0
  - state IDLE
  - HEX all ones
  - running 0
  - The hold counter is 0.

## Timing
- HEX is registered. A change to buffer or offset at edge N appears on HEX at edge N+1.
- offset and running are registered directly; they show the new value after edge N.
- In RUN with enable held high from cycle 0, the first tick lands on the TICK_DIV-th rising edge after entering RUN. Later ticks follow every TICK_DIV cycles.
- Toggling dir mid-interval does not reset the prescaler.
- RESET mid-scroll returns to the reset values on the next edge. The previous message is lost.
- load and step are level-sampled. Holding either high repeats the action every cycle; the source must pulse them.

## Configuration
- MARQUEE_WRAP_HOLD_EN defined:
  - When a RUN tick moves offset to 0, the FSM enters HOLD.
  - HOLD counts HOLD_TICKS further prescaler ticks without moving offset, then returns to RUN. The next tick then moves offset.
  - running=1 in HOLD.
  - enable=0 exits to IDLE and clears the hold counter.
- Macro undefined: the HOLD state and hold counter are absent. Offset moves on every RUN tick.

## Test plan
Simulation uses TICK_DIV=4, MSG_LEN=8, NUM_DIGITS=8.
- **Reset and blank:** assert RESET 2 cycles → HEX = 56'hFFFFFFFFFFFFFF, offset=0, running=0.
- **Load HELLO:** load pulse with codes H,E,L,L,O,blank,blank,blank (enable=0) → one cycle later the leftmost digit = 1001000 and digit 4 = 0000001, offset=0.
- **Left scroll:** enable=1, dir=0 → offset=1 after 4 cycles, leftmost digit shows E. After 32 cycles offset=0 again.
- **Right wrap and step:** enable=0, dir=1, step pulse at offset 0 → offset=7, leftmost digit blank. Step pulses while enable=1 → no change.
- **Load/tick collision:** load asserted on the terminal prescaler cycle → offset=0 and prescaler restarts. The next move occurs 4 cycles later.
- **With MARQUEE_WRAP_HOLD_EN, HOLD_TICKS=2:** after offset wraps to 0, it stays 0 for 12 cycles (the wrap tick plus 2 hold ticks), then becomes 1. Without the macro, offset becomes 1 4 cycles after the wrap.
